// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbitration slice: FSM encoding,
// default byte width and a width helper for counters and indices.
package uart_pkg;

    localparam int DATA_W_DEF = 8;

    localparam logic [1:0] ST_IDLE_C      = 2'd0;
    localparam logic [1:0] ST_LAUNCH_C    = 2'd1;
    localparam logic [1:0] ST_WAIT_ACK_C  = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE_C = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE      = ST_IDLE_C,
        ST_LAUNCH    = ST_LAUNCH_C,
        ST_WAIT_ACK  = ST_WAIT_ACK_C,
        ST_WAIT_DONE = ST_WAIT_DONE_C
    } arb_state_e;

    // Smallest w with 2**w >= value (0 for value <= 1).
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                w = i + 1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: searches from rr_ptr+1 upward with wrap,
// considering only requests that survive the eligibility mask.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    input  logic [NUM_REQ-1:0] mask,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_any
);

    logic [NUM_REQ-1:0] eligible_s;
    int                 idx_s;

    // Priority search starting just past the last owner.
    always_comb begin
        eligible_s = req & mask;
        idx_s      = 0;
        grant      = '0;
        grant_idx  = '0;
        grant_any  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_s = (int'(rr_ptr) + k) % NUM_REQ;
            if (!grant_any && eligible_s[idx_s]) begin
                grant[idx_s] = 1'b1;
                grant_idx    = ID_W'(idx_s);
                grant_any    = 1'b1;
            end else begin
                grant_any = grant_any;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte streams,
// with packet locking and a start-acknowledge timeout.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int ID_W          = 2,
    parameter int START_TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_busy,
    output logic [ID_W-1:0]           grant_id,
    output logic                      grant_valid,
    output logic                      locked,
    output logic                      timeout_err
);

    localparam int              CNT_W    = clog2(START_TIMEOUT + 1);
    // The counter is compared before its increment, so the error fires as it reaches START_TIMEOUT-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 2);

    arb_state_e          state_r;
    logic [ID_W-1:0]     rr_ptr_r;
    logic [CNT_W-1:0]    cnt_r;

    logic [NUM_REQ-1:0]  lock_mask_s;
    logic [NUM_REQ-1:0]  pick_grant_s;
    logic [ID_W-1:0]     pick_idx_s;
    logic                pick_any_s;
    logic                arb_en_s;
    logic [DATA_W-1:0]   winner_data_s;
    logic                winner_last_s;

    // While a packet is locked only its owner may compete.
    always_comb begin
        lock_mask_s = '0;
        if (locked) begin
            lock_mask_s[grant_id] = 1'b1;
        end else begin
            lock_mask_s = '1;
        end
    end

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_r),
        .mask      (lock_mask_s),
        .grant     (pick_grant_s),
        .grant_idx (pick_idx_s),
        .grant_any (pick_any_s)
    );

    // Accept strobe is combinational so a valid byte is taken in the same cycle.
    always_comb begin
        arb_en_s      = (state_r == ST_IDLE) && !tx_busy;
        winner_data_s = req_data[int'(pick_idx_s)*DATA_W +: DATA_W];
        winner_last_s = req_last[pick_idx_s];
        if (arb_en_s) begin
            req_ready = pick_grant_s;
        end else begin
            req_ready = '0;
        end
    end

    // Arbitration FSM with capture register, lock flag and start timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            rr_ptr_r    <= ID_W'(NUM_REQ - 1);
            cnt_r       <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            locked      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            tx_start    <= 1'b0;
            timeout_err <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (arb_en_s && pick_any_s) begin
                        tx_data     <= winner_data_s;
                        grant_id    <= pick_idx_s;
                        rr_ptr_r    <= pick_idx_s;
                        locked      <= ~winner_last_s;
                        tx_start    <= 1'b1;
                        grant_valid <= 1'b1;
                        state_r     <= ST_LAUNCH;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LAUNCH: begin
                    cnt_r   <= '0;
                    state_r <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (tx_busy) begin
                        state_r <= ST_WAIT_DONE;
                    end else if (cnt_r == CNT_LAST) begin
                        // Transmitter never started: drop the byte and release any lock.
                        cnt_r       <= cnt_r + CNT_W'(1);
                        timeout_err <= 1'b1;
                        locked      <= 1'b0;
                        grant_valid <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        grant_valid <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT_DONE;
                    end
                end
                default: begin
                    grant_valid <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table for grant order and locking,
// plus hand sequences for timeout, busy guard and mid-frame reset.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        grant_valid;
    logic        locked;
    logic        timeout_err;

    logic        auto_en;
    logic        busy_auto;
    logic        busy_man;
    int          busy_len;

    int          n_checks;
    int          n_errors;
    int          overlap_cnt;
    int          multi_cnt;

    assign tx_busy = auto_en ? busy_auto : busy_man;

    uart_tx_arbiter #(
        .NUM_REQ       (4),
        .DATA_W        (8),
        .ID_W          (2),
        .START_TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .locked      (locked),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transmitter model: busy rises 2 clk after tx_start and lasts busy_len clk.
    initial begin
        busy_auto = 1'b0;
        forever begin
            @(posedge clk);
            if (auto_en && tx_start) begin
                @(posedge clk);
                #1 busy_auto = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1 busy_auto = 1'b0;
            end
        end
    end

    // Protocol monitors: no start inside a busy window, never more than one ready.
    initial begin
        overlap_cnt = 0;
        multi_cnt   = 0;
    end
    always @(negedge clk) begin
        if (rst) begin
            if (tx_start && tx_busy) overlap_cnt <= overlap_cnt + 1;
            if ($countones(req_ready) > 1) multi_cnt <= multi_cnt + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic wait_idle(input string nm);
        for (int c = 0; c < 400; c++) begin
            if (!grant_valid) break;
            @(negedge clk);
        end
        chk(nm, {31'd0, grant_valid}, 32'd0);
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  last;
        logic [3:0]  exp_ready;
        logic [7:0]  exp_data;
        logic        exp_locked;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    initial begin
        int first;
        int bad;
        int c;
        logic seen_busy;

        n_checks = 0;
        n_errors = 0;

        // Round robin from reset, then a 3-byte locked packet, then mixed owners.
        vecs[0]  = '{4'b1111, 32'h13121110, 4'b1111, 4'b0001, 8'h10, 1'b0};
        vecs[1]  = '{4'b1111, 32'h13121110, 4'b1111, 4'b0010, 8'h11, 1'b0};
        vecs[2]  = '{4'b1111, 32'h13121110, 4'b1111, 4'b0100, 8'h12, 1'b0};
        vecs[3]  = '{4'b1111, 32'h13121110, 4'b1111, 4'b1000, 8'h13, 1'b0};
        vecs[4]  = '{4'b1111, 32'h13121110, 4'b1111, 4'b0001, 8'h10, 1'b0};
        vecs[5]  = '{4'b0011, 32'h00001A77, 4'b0000, 4'b0010, 8'h1A, 1'b1};
        vecs[6]  = '{4'b0011, 32'h00001B77, 4'b0000, 4'b0010, 8'h1B, 1'b1};
        vecs[7]  = '{4'b0011, 32'h00001C77, 4'b0010, 4'b0010, 8'h1C, 1'b0};
        vecs[8]  = '{4'b0001, 32'h00000077, 4'b0001, 4'b0001, 8'h77, 1'b0};
        vecs[9]  = '{4'b1001, 32'h99000077, 4'b1001, 4'b1000, 8'h99, 1'b0};
        vecs[10] = '{4'b1001, 32'h99000077, 4'b1001, 4'b0001, 8'h77, 1'b0};

        rst       = 1'b0;
        req_valid = 4'd0;
        req_data  = 32'd0;
        req_last  = 4'd0;
        auto_en   = 1'b1;
        busy_man  = 1'b0;
        busy_len  = 100;

        repeat (3) @(negedge clk);
        chk("reset_outputs", {14'd0, req_ready, tx_start, tx_data, grant_id, grant_valid, locked, timeout_err}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Single request with a 100-clk frame.
        req_valid = 4'b0100;
        req_data  = 32'h005A0000;
        req_last  = 4'b0100;
        #1 chk("single_ready", {28'd0, req_ready}, 32'h4);
        @(negedge clk);
        chk("single_start", {31'd0, tx_start}, 32'd1);
        chk("single_grant_id", {30'd0, grant_id}, 32'd2);
        chk("single_data", {24'd0, tx_data}, 32'h5A);
        chk("single_locked", {31'd0, locked}, 32'd0);
        chk("single_gv", {31'd0, grant_valid}, 32'd1);
        req_valid = 4'd0;
        @(negedge clk);
        chk("single_start_pulse", {31'd0, tx_start}, 32'd0);
        seen_busy = 1'b0;
        bad = 0;
        for (c = 0; c < 300; c++) begin
            @(negedge clk);
            if (tx_data !== 8'h5A) bad++;
            if (tx_busy) seen_busy = 1'b1;
            else if (seen_busy) break;
        end
        chk("single_busy_seen", {31'd0, seen_busy}, 32'd1);
        chk("single_data_hold", bad, 32'd0);
        chk("single_gv_in_done", {31'd0, grant_valid}, 32'd1);
        @(negedge clk);
        chk("single_back_idle", {31'd0, grant_valid}, 32'd0);

        // Fresh reset so the table starts with requester 0 first.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        busy_len = 6;

        for (int i = 0; i < NV; i++) begin
            req_valid = vecs[i].valid;
            req_data  = vecs[i].data;
            req_last  = vecs[i].last;
            #1;
            for (c = 0; c < 400; c++) begin
                if (req_ready != 4'd0) break;
                @(negedge clk);
                #1;
            end
            chk($sformatf("vec%0d_ready", i), {28'd0, req_ready}, {28'd0, vecs[i].exp_ready});
            @(negedge clk);
            if (i == NV - 1) req_valid = 4'd0;
            chk($sformatf("vec%0d_start", i), {31'd0, tx_start}, 32'd1);
            chk($sformatf("vec%0d_data", i), {24'd0, tx_data}, {24'd0, vecs[i].exp_data});
            chk($sformatf("vec%0d_locked", i), {31'd0, locked}, {31'd0, vecs[i].exp_locked});
            chk($sformatf("vec%0d_gid", i), {28'd0, 4'(1) << grant_id}, {28'd0, vecs[i].exp_ready});
            wait_idle($sformatf("vec%0d_idle", i));
        end

        // Timeout: transmitter never acknowledges.
        auto_en   = 1'b0;
        busy_man  = 1'b0;
        req_valid = 4'b0100;
        req_data  = 32'h00C30000;
        req_last  = 4'b0000;
        #1 chk("to_ready", {28'd0, req_ready}, 32'h4);
        @(negedge clk);
        chk("to_start", {31'd0, tx_start}, 32'd1);
        chk("to_locked_set", {31'd0, locked}, 32'd1);
        req_valid = 4'b0001;
        req_data  = 32'h00000077;
        req_last  = 4'b0001;
        first = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (timeout_err) begin
                first = k;
                break;
            end
        end
        chk("to_latency", first, 32'd16);
        chk("to_locked_clear", {31'd0, locked}, 32'd0);
        chk("to_gv_clear", {31'd0, grant_valid}, 32'd0);
        #1 chk("to_next_ready", {28'd0, req_ready}, 32'h1);
        auto_en = 1'b1;
        @(negedge clk);
        chk("to_pulse_width", {31'd0, timeout_err}, 32'd0);
        chk("to_next_start", {31'd0, tx_start}, 32'd1);
        chk("to_next_gid", {30'd0, grant_id}, 32'd0);
        req_valid = 4'd0;
        wait_idle("to_next_idle");

        // Busy guard: foreign frame in progress while idle.
        auto_en   = 1'b0;
        busy_man  = 1'b1;
        req_valid = 4'b1000;
        req_data  = 32'hE7000000;
        req_last  = 4'b0000;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (req_ready != 4'd0) bad++;
        end
        chk("guard_no_ready", bad, 32'd0);
        chk("guard_no_grant", {31'd0, grant_valid}, 32'd0);
        busy_len = 20;
        busy_man = 1'b0;
        auto_en  = 1'b1;
        #1 chk("guard_ready_after", {28'd0, req_ready}, 32'h8);
        @(negedge clk);
        chk("guard_start", {31'd0, tx_start}, 32'd1);
        req_valid = 4'd0;

        // Reset asserted in WAIT_DONE with a lock held.
        repeat (5) @(negedge clk);
        chk("rst_pre_state", {29'd0, grant_valid, tx_busy, locked}, 32'h7);
        rst = 1'b0;
        #1 chk("rst_async_outputs", {14'd0, req_ready, tx_start, tx_data, grant_id, grant_valid, locked, timeout_err}, 32'd0);
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 4'b1001;
        req_data  = 32'hE7000077;
        req_last  = 4'b1001;
        #1 chk("rst_guard_ready", {28'd0, req_ready}, 32'd0);
        for (c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!tx_busy) break;
        end
        #1 chk("rst_first_winner", {28'd0, req_ready}, 32'h1);
        @(negedge clk);
        chk("rst_first_gid", {30'd0, grant_id}, 32'd0);
        chk("rst_first_data", {24'd0, tx_data}, 32'h77);
        req_valid = 4'd0;
        wait_idle("rst_final_idle");

        chk("no_start_in_busy", overlap_cnt, 32'd0);
        chk("ready_onehot", multi_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx_fsm transmitter between NUM_REQ byte-stream requesters using round-robin arbitration, with optional packet locking.
- Captures one byte per grant and pulses tx_start to the transmitter.
- Tracks tx_busy through each frame and flags a transmitter that never starts.
- Sits between client logic and the tx_unit inside uart_top.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width; must match uart_tx_fsm tx_data
ID_W, 2, grant index width; must equal clog2(NUM_REQ)
START_TIMEOUT, 16, clk cycles allowed from tx_start until tx_busy rises

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester byte available
req_data  in  NUM_REQ*DATA_W  packed bytes; requester i occupies bits [i*DATA_W +: DATA_W]
req_last  in  NUM_REQ  byte is the final byte of a packet; releases the lock
req_ready  out  NUM_REQ  one-hot, one-cycle accept strobe
tx_start  out  1  one-cycle start pulse to uart_tx_fsm
tx_data  out  DATA_W  byte to transmitter; stable from capture until return to IDLE
tx_busy  in  1  transmitter busy, from uart_tx_fsm
grant_id  out  ID_W  index of the current/last owner
grant_valid  out  1  high from capture until the frame completes (LAUNCH..WAIT_DONE)
locked  out  1  packet lock held by grant_id
timeout_err  out  1  one-cycle pulse when tx_busy never rose

Behaviour:
- Reset (rst=0, async) values:
  - state=IDLE
  - all outputs 0
  - rr_ptr=NUM_REQ-1, so requester 0 has first priority
  - lock flag=0, timeout counter=0
- States: IDLE, LAUNCH, WAIT_ACK, WAIT_DONE.
- IDLE:
  - Arbitration is enabled only when tx_busy=0.
  - Unlocked: the winner is the first i with req_valid[i]=1, searching rr_ptr+1, rr_ptr+2, ... with wrap modulo NUM_REQ.
  - Locked: only grant_id is eligible. Other requesters are ignored even if valid. The block waits indefinitely for the owner.
  - req_ready[winner] is combinational: state==IDLE && tx_busy==0 && winner valid. It may depend on req_valid. Requesters must not make valid depend on ready.
  - Capture cycle (valid&ready):
    - tx_data <= the winner's req_data
    - grant_id <= winner
    - rr_ptr <= winner
    - locked <= ~req_last[winner]
    - next state LAUNCH
- LAUNCH: tx_start=1 for exactly this cycle; counter cleared; next state WAIT_ACK.
- WAIT_ACK:
  - tx_busy=1 -> WAIT_DONE.
  - Otherwise the counter increments each cycle.
  - When the counter reaches START_TIMEOUT-1:
    - timeout_err pulses for 1 cycle
    - locked is cleared
    - the byte is dropped (no retry)
    - next state IDLE
- WAIT_DONE: stay while tx_busy=1; on tx_busy=0 -> IDLE.
- Latency: req_valid (idle, tx free) to req_ready is 0 cycles; capture to tx_start is 1 cycle.
- Throughput: at most one byte per UART frame plus 3 clk of overhead.
- Simultaneous requests: exactly one req_ready per capture. After owner k, the next unlocked search starts at k+1. Every continuously-valid requester is served within NUM_REQ grants.
- Single requester always valid: it is granted back-to-back.
- tx_busy already high in IDLE (foreign or residual frame): no grant until it drops.
- Reset asserted mid-frame: the block returns to IDLE immediately. tx_start is never glitched. The lock is released. The transmitter finishes on its own, and after reset the IDLE tx_busy guard prevents overlap.
- grant_valid=1 in LAUNCH, WAIT_ACK, WAIT_DONE.

Decomposition:
- Shared package uart_pkg:
  - state encoding localparams (IDLE=0, LAUNCH=1, WAIT_ACK=2, WAIT_DONE=3)
  - DATA_W default
  - clog2 helper function for counter and ID widths
- One natural sub-module: uart_rr_pick. It is combinational round-robin: it takes a request vector, rr_ptr and a lock mask, and outputs a one-hot grant plus an index.
- The FSM, capture register and timeout counter stay in the top level.

Test Plan:
- Single request: req_valid[2]=1, data=0x5A, last=1, tx_busy model rises 2 clk after start and lasts 100 clk. Required: req_ready[2] in that same cycle; tx_start 1 clk later; tx_data=0x5A held; grant_id=2; locked=0; returns to IDLE after busy falls.
- Round-robin: all four valid continuously with data 0x10..0x13, last=1. Required capture order 0,1,2,3,0; exactly one req_ready per capture; never two starts inside one busy window.
- Packet lock: requester 1 sends 3 bytes (last on the 3rd) while requester 0 is constantly valid. Required: bytes 1a, 1b, 1c are sent consecutively with locked=1 until the 3rd capture; requester 0 is granted next.
- Timeout: tx_busy held 0 after tx_start. Required: timeout_err pulses exactly START_TIMEOUT clk after LAUNCH; locked clears; the next request is granted normally.
- Busy guard/reset: tx_busy=1 while in IDLE with req_valid[3]=1 -> no req_ready until busy falls. Separately, assert rst=0 during WAIT_DONE -> all outputs 0 asynchronously and rr_ptr reset, so requester 0 wins first after release.
